// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV bit positions and ALU control encodings.
package cpu_pkg;

    // Condition field encodings carried by every instruction
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // Bit positions inside the {N,Z,C,V} flags vector
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // ALU operation select driven by the decoder
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction executes
// given its condition field and the current NZCV flags.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;

    assign n_f = flags[N_IDX];
    assign z_f = flags[Z_IDX];
    assign c_f = flags[C_IDX];
    assign v_f = flags[V_IDX];

    // Decode the condition field; the reserved code never executes
    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = (n_f == v_f);
            COND_LT: cond_ex = (n_f != v_f);
            COND_GT: cond_ex = ~z_f & (n_f == v_f);
            COND_LE: cond_ex = z_f | (n_f != v_f);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cond_stage.sv
// Execute-stage conditional logic: owns the NZCV flags register, gates the
// side-effecting controls of each instruction by its condition, and registers
// the payload toward the memory stage with a valid/ready handshake.
module exec_cond_stage
    import cpu_pkg::*;
#(
    parameter logic [3:0] FLAGS_INIT = 4'b0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic [1:0]  flag_w,
    input  logic        pcs,
    input  logic        reg_w,
    input  logic        mem_w,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    input  logic [31:0] write_data,
    input  logic [3:0]  wa3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_write_data,
    output logic [3:0]  out_wa3,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_write,
    output logic [3:0]  flags
);

    logic cond_ex;
    logic accept;

    // Condition is judged against the architectural flags, not this cycle's ALU flags
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // Flags update only for an accepted instruction whose condition passed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= FLAGS_INIT;
        end else if (accept && cond_ex) begin
            if (flag_w[1]) begin
                flags[N_IDX] <= alu_flags[N_IDX];
                flags[Z_IDX] <= alu_flags[Z_IDX];
            end
            if (flag_w[0]) begin
                flags[C_IDX] <= alu_flags[C_IDX];
                flags[V_IDX] <= alu_flags[V_IDX];
            end
        end
    end

    // Output valid: flush kills, accept loads, a drain without refill empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload register loads on accept and otherwise holds; failed conditions still pass through with controls cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result     <= '0;
            out_write_data <= '0;
            out_wa3        <= '0;
            pc_src         <= 1'b0;
            reg_write      <= 1'b0;
            mem_write      <= 1'b0;
        end else if (accept) begin
            out_result     <= alu_result;
            out_write_data <= write_data;
            out_wa3        <= wa3;
            pc_src         <= pcs & cond_ex;
            reg_write      <= reg_w & cond_ex;
            mem_write      <= mem_w & cond_ex;
        end
    end

endmodule

// File: doc/exec_cond_stage.md
EXEC_COND_STAGE -- requirements
Module: exec_cond_stage

Interface
REQ-001 Parameter FLAGS_INIT, default 4'b0000: reset value of the NZCV flags register, bit order {N,Z,C,V}.
REQ-002 Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  kill the in-flight and incoming instruction this cycle.
REQ-006 in_valid  input  1  upstream execute-slot payload valid.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 cond  input  4  instruction condition field.
REQ-009 flag_w  input  2  flag write enables: [1] updates N,Z; [0] updates C,V.
REQ-010 pcs  input  1  instruction writes PC.
REQ-011 reg_w  input  1  instruction writes the register file.
REQ-012 mem_w  input  1  instruction writes memory.
REQ-013 alu_result  input  32  ALU result.
REQ-014 alu_flags  input  4  ALU {Negative,Zero,Carry,Overflow}.
REQ-015 write_data  input  32  store data.
REQ-016 wa3  input  4  destination register index.
REQ-017 out_valid  output  1  registered payload valid toward the memory stage.
REQ-018 out_ready  input  1  memory stage accepts the payload.
REQ-019 out_result, out_write_data  output  32 each  registered alu_result and write_data.
REQ-020 out_wa3  output  4  registered wa3.
REQ-021 pc_src, reg_write, mem_write  output  1 each  registered pcs/reg_w/mem_w, each ANDed with cond_ex.
REQ-022 flags  output  4  current NZCV flags register.

Function
REQ-023 in_ready SHALL equal (~out_valid | out_ready); accept = in_valid & in_ready & ~flush.
REQ-024 cond_ex SHALL be evaluated combinationally on cond against the flags register (not alu_flags).
REQ-025 Conditions: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
REQ-026 Conditions: 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 SHALL be 0 (reserved, never executes).
REQ-027 On accept & cond_ex: flag_w[1] loads N,Z from alu_flags[3:2]; flag_w[0] loads C,V from alu_flags[1:0]; unselected bits hold.
REQ-028 Flags SHALL NOT change without accept, when cond_ex=0, or when flush=1.
REQ-029 On accept, the output register SHALL load the full payload and gated controls and set out_valid=1; latency is exactly one cycle.
REQ-030 A failed-condition instruction SHALL still pass through with out_valid=1 and pc_src=reg_write=mem_write=0.
REQ-031 Without accept, out_valid SHALL clear when out_ready=1 and hold otherwise; payload holds while out_valid & ~out_ready.
REQ-032 Simultaneous drain and accept (out_valid & out_ready & in_valid) SHALL replace the payload with no bubble.
REQ-033 Back-to-back instructions: instruction N+1 SHALL see flags written by instruction N.
REQ-034 flush SHALL force out_valid=0 next cycle, overriding accept and drain.

Reset
REQ-035 While rst_n=0: out_valid, pc_src, reg_write, mem_write=0; out_result, out_write_data, out_wa3=0; flags=FLAGS_INIT; in_ready=1.
REQ-036 Reset asserted mid-transfer SHALL discard the payload immediately and update no flags.

Structure
REQ-037 The shared package cpu_pkg SHALL hold the cond_t enum (the 16 codes), the flag bit index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0, and the ALUControl encodings.
REQ-038 Condition evaluation SHALL be a combinational sub-module, cond_check, with inputs cond and flags and output cond_ex.

Verification
REQ-039 Reset: with FLAGS_INIT=4'b0100 and cond=0000 EQ accepted -> flags=0100 and reg_write=1 one cycle later.
REQ-040 SUBS: alu_flags=0110 with flag_w=11 and AL, then next cycle cond=0001 NE with reg_w=1 -> flags=0110 and the second instruction has reg_write=0 and out_valid=1.
REQ-041 Partial flag write: flags=1111, then AL with flag_w=10 and alu_flags=0000 -> flags=0011.
REQ-042 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 and alu_result=32'hDEADBEEF -> in_ready=0 and out_result stays DEADBEEF; on release, the next payload loads on the same edge.
REQ-043 Flush: a flag-setting instruction with flag_w=11 and flush=1 -> out_valid=0 next cycle and flags unchanged.
REQ-044 Condition 1111 with pcs=1 and mem_w=1 -> pc_src=0, mem_write=0, out_valid=1.
